// File: rtl/add_sub_pkg.sv
// ---------------------------------------------------------------------------
// add_sub_pkg
// Shared constants for the registered ripple-carry adder/subtractor.
//   DEFAULT_WIDTH : default operand/result width
//   MODE_ADD/SUB  : encodings of the M (mode) input
// ---------------------------------------------------------------------------
package add_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 2;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : add_sub_pkg

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit combinational full adder, the stage cell of the ripple chain.
//   a, b  : operand bits
//   cin   : carry in from the previous stage
//   s     : sum bit
//   cout  : carry out to the next stage
// ---------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    // Propagate term shared by sum and carry.
    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule : full_adder

// File: rtl/add_sub.sv
// ---------------------------------------------------------------------------
// add_sub
// Registered WIDTH-bit adder/subtractor built from a ripple chain of
// full adders. Subtraction is A + ~B + 1: B is inverted by an XOR row
// driven by M and M also feeds the chain carry-in.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears S and Cout
//   A, B  : unsigned operands
//   M     : mode, MODE_ADD (0) = A+B, MODE_SUB (1) = A-B
//   S     : registered result, wraps modulo 2^WIDTH
//   Cout  : registered carry out of the MSB; in subtract mode 1 = no borrow
// ---------------------------------------------------------------------------
module add_sub
    import add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_carry;

    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    // Conditional inversion of B and the +1 for two's-complement subtract.
    assign w_bx       = B ^ {WIDTH{M}};
    assign w_carry[0] = M;

    // Ripple chain; carry of stage i feeds stage i+1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (A[i]),
            .b    (w_bx[i]),
            .cin  (w_carry[i]),
            .s    (w_sum[i]),
            .cout (w_carry[i+1])
        );
    end

    // Output register; cleared asynchronously so no partial result escapes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_carry[WIDTH];
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;

endmodule : add_sub

// File: tb/tb_add_sub.sv
// ---------------------------------------------------------------------------
// tb_add_sub
// Directed and random checks of add_sub (WIDTH = 2) against an arithmetic
// reference model.
// ---------------------------------------------------------------------------
module tb_add_sub;
    import add_sub_pkg::*;

    localparam int unsigned W = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         M;
    logic [W-1:0] S;
    logic         Cout;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .M     (M),
        .S     (S),
        .Cout  (Cout)
    );

    always #5 clk = ~clk;

    // Plain integer arithmetic: add, or A + (2^W-1-B) + 1 for subtract.
    function automatic logic [W:0] ref_model(input int unsigned a, input int unsigned b,
                                             input logic m);
        int unsigned mask;
        int unsigned r;
        mask = (1 << W) - 1;
        if (m == MODE_SUB) r = a + (mask - b) + 1;
        else               r = a + b;
        return (W+1)'(r);
    endfunction

    task automatic check(input string tag, input logic [W:0] exp);
        n_checks++;
        assert ({Cout, S} === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed {Cout,S}=%b expected %b", tag, {Cout, S}, exp);
        end
    endtask

    // Drive at the falling edge, capture on the rising edge, check at the next fall.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [W:0] exp, input string tag);
        A = a;
        B = b;
        M = m;
        @(posedge clk);
        @(negedge clk);
        check(tag, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        A = '0;
        B = '0;
        M = MODE_ADD;

        @(negedge clk);
        check("reset_state", 3'b000);
        rst_n = 1'b1;

        // Directed cases
        step(2'd3, 2'd1, MODE_ADD, 3'b100, "add_overflow");
        step(2'd2, 2'd1, MODE_ADD, 3'b011, "add_no_overflow");
        step(2'd2, 2'd1, MODE_SUB, 3'b101, "sub_no_borrow");
        step(2'd0, 2'd0, MODE_SUB, 3'b100, "sub_equal_zero");
        step(2'd1, 2'd2, MODE_SUB, 3'b011, "sub_borrow_a");
        step(2'd0, 2'd3, MODE_SUB, 3'b001, "sub_borrow_b");
        step(2'd3, 2'd3, MODE_SUB, 3'b100, "sub_equal_max");

        // Asynchronous reset mid-cycle, hold, then release
        step(2'd3, 2'd3, MODE_ADD, 3'b110, "pre_reset");
        #2 rst_n = 1'b0;
        #1 check("reset_async", 3'b000);
        A = 2'd1;
        B = 2'd2;
        M = MODE_SUB;
        @(posedge clk);
        @(negedge clk);
        check("reset_hold", 3'b000);
        A = 2'd3;
        B = 2'd3;
        M = MODE_ADD;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_release", 3'b110);

        // Exhaustive sweep, back-to-back
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    step(W'(a), W'(b), 1'(m), ref_model(a, b, 1'(m)), "sweep");
                end
            end
        end

        // Mode toggle with fixed operands
        for (int i = 0; i < 8; i++) begin
            if ((i % 2) == 0) step(2'd2, 2'd3, MODE_ADD, 3'b101, "toggle_add");
            else              step(2'd2, 2'd3, MODE_SUB, 3'b011, "toggle_sub");
        end

        // Random operands and modes
        for (int i = 0; i < 40; i++) begin
            int unsigned ra;
            int unsigned rb;
            logic        rm;
            ra = $urandom_range(0, 3);
            rb = $urandom_range(0, 3);
            rm = 1'($urandom_range(0, 1));
            step(W'(ra), W'(rb), rm, ref_model(ra, rb, rm), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_add_sub
